// File: rtl/rd_buffer.sv
// Read-return buffer: memory-side beats land in a RAM, user side pops them FWFT.
// A reservation counter keeps room for every outstanding burst so returned beats are never dropped.
module rd_buffer #(
  parameter int DEPTH_LOG2  = 6,
  parameter int BURST_BEATS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqRead,
  output logic                  CanIssue,
  input  logic [127:0]          MD,
  input  logic                  MDvalid,
  output logic [127:0]          RD,
  output logic                  RDvalid,
  input  logic                  RDen,
  output logic [DEPTH_LOG2:0]   Outstanding,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW:0]   BURST_W = (CW+1)'(BURST_BEATS);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_BEATS);

  logic [127:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d, outst_q, outst_d;
  logic [127:0]          rd_q, rd_d;
  logic                  rdvalid_q, rdvalid_d, err_q, err_d;
  logic [CW:0]           free;
  logic                  can_issue, req_acc, md_acc, pop;

  // free space is derived only from registered state so CanIssue has no input path
  assign free      = DEPTH_W - {1'b0, count_q} - {1'b0, outst_q};
  assign can_issue = (free >= BURST_W);
  assign req_acc   = ReqRead & can_issue;
  assign md_acc    = MDvalid & (outst_q != '0);
  assign pop       = RDen & rdvalid_q;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    outst_d   = outst_q;
    rd_d      = rd_q;
    rdvalid_d = rdvalid_q;
    err_d     = err_q;

    if (md_acc) wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (pop)    rptr_d = rptr_q + DEPTH_LOG2'(1);

    if (md_acc && !pop)      count_d = count_q + CW'(1);
    else if (!md_acc && pop) count_d = count_q - CW'(1);

    if (req_acc) outst_d = outst_d + BURST_C;
    if (md_acc)  outst_d = outst_d - CW'(1);

    rdvalid_d = (count_d != '0);
    // when the next head is the beat being written right now, bypass the RAM
    if (count_d != '0)
      rd_d = (md_acc && (wptr_q == rptr_d)) ? MD : mem[rptr_d];

    err_d = err_q | (ReqRead & ~can_issue) | (MDvalid & (outst_q == '0))
                  | (RDen & ~rdvalid_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      rd_q      <= '0;
      rdvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      rd_q      <= rd_d;
      rdvalid_q <= rdvalid_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (md_acc) mem[wptr_q] <= MD;
  end

  assign CanIssue    = can_issue;
  assign RD          = rd_q;
  assign RDvalid     = rdvalid_q;
  assign Outstanding = outst_q;
  assign Count       = count_q;
  assign Err         = err_q;

endmodule

// File: tb/tb_rd_buffer.sv
// Randomized bench for rd_buffer checked against a queue-based model of the buffer.
module tb_rd_buffer;

  localparam int DL    = 6;
  localparam int DEPTH = 64;
  localparam int BURST = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         ReqRead, MDvalid, RDen;
  logic [127:0] MD;
  logic         CanIssue, RDvalid, Err;
  logic [127:0] RD;
  logic [DL:0]  Outstanding, Count;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [127:0] modelQ[$];
  int           modelOut;
  bit           modelErr;

  rd_buffer #(.DEPTH_LOG2(DL), .BURST_BEATS(BURST)) dut (
    .Clk(Clk), .Reset(Reset), .ReqRead(ReqRead), .CanIssue(CanIssue),
    .MD(MD), .MDvalid(MDvalid), .RD(RD), .RDvalid(RDvalid), .RDen(RDen),
    .Outstanding(Outstanding), .Count(Count), .Err(Err)
  );

  always #5 Clk = ~Clk;

  function automatic bit modelCan();
    return (DEPTH - modelQ.size() - modelOut) >= BURST;
  endfunction

  function automatic logic [127:0] randBeat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ":count"},    128'(Count),       128'(modelQ.size()));
    checkOutput({where, ":outst"},    128'(Outstanding), 128'(modelOut));
    checkOutput({where, ":rdvalid"},  128'(RDvalid),     128'(modelQ.size() != 0));
    checkOutput({where, ":canissue"}, 128'(CanIssue),    128'(modelCan()));
    checkOutput({where, ":err"},      128'(Err),         128'(modelErr));
    if (modelQ.size() != 0) checkOutput({where, ":rd"}, RD, modelQ[0]);
  endtask

  task automatic applyStimulus(input bit req, input bit mdv, input logic [127:0] md,
                               input bit rden, input string where);
    int  sz;
    bit  can;
    ReqRead = req;
    MDvalid = mdv;
    MD      = md;
    RDen    = rden;
    sz  = modelQ.size();
    can = modelCan();
    @(posedge Clk);
    if (req && !can)            modelErr = 1'b1;
    if (mdv && modelOut == 0)   modelErr = 1'b1;
    if (rden && sz == 0)        modelErr = 1'b1;
    if (rden && sz != 0)        void'(modelQ.pop_front());
    if (mdv && modelOut != 0) begin
      modelQ.push_back(md);
      modelOut--;
    end
    if (req && can) modelOut += BURST;
    #1;
    checkAll(where);
  endtask

  task automatic doReset();
    ReqRead = 1'b0;
    MDvalid = 1'b0;
    RDen    = 1'b0;
    MD      = '0;
    Reset   = 1'b1;
    #1;
    modelQ.delete();
    modelOut = 0;
    modelErr = 1'b0;
    checkAll("reset");
    checkOutput("reset:rd", RD, 128'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    int issued, pushed;
    logic [127:0] beatB;
    bit req, mdv, rden;

    doReset();
    repeat (3) applyStimulus(0, 0, '0, 0, "idle");

    // one burst, four beats, then drain
    applyStimulus(1, 0, '0, 0, "req1");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 128'(i), 0, "beat");
    checkOutput("burst:rd_first", RD, 128'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, "pop");
    applyStimulus(0, 0, '0, 0, "drained");

    // fill all reservations, then an illegal 17th request
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, '0, 0, "reserve");
    checkOutput("reserve:canissue_low", 128'(CanIssue), 128'd0);
    applyStimulus(1, 0, '0, 0, "req17");
    checkOutput("req17:outst", 128'(Outstanding), 128'd64);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, randBeat(), 0, "resbeat");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, "respop");
    checkOutput("respop:canissue", 128'(CanIssue), 128'd1);
    for (int c = 0; c < 200 && (modelOut > 0 || modelQ.size() != 0); c++)
      applyStimulus(0, modelOut > 0, randBeat(), modelQ.size() != 0, "resdrain");

    // long stream wrapping the pointers several times
    doReset();
    issued = 0;
    pushed = 0;
    for (int c = 0; c < 3000 && (pushed < 200 || modelQ.size() != 0); c++) begin
      req = modelCan() && (issued < 200);
      mdv = (modelOut > 0);
      if (req) issued += BURST;
      if (mdv) pushed++;
      applyStimulus(req, mdv, randBeat(), 1, "stream");
    end
    checkOutput("stream:pushed", 128'(pushed), 128'd200);

    // push and pop together with a single entry stored
    doReset();
    applyStimulus(1, 0, '0, 0, "c1req");
    applyStimulus(0, 1, randBeat(), 0, "c1beatA");
    applyStimulus(0, 0, '0, 0, "c1hold");
    beatB = randBeat();
    applyStimulus(0, 1, beatB, 1, "c1swap");
    checkOutput("c1swap:count", 128'(Count), 128'd1);
    checkOutput("c1swap:rd", RD, beatB);
    checkOutput("c1swap:rdvalid", 128'(RDvalid), 128'd1);

    // unsolicited beat, then reset in the middle of a burst
    doReset();
    applyStimulus(0, 1, randBeat(), 0, "unsolicited");
    checkOutput("unsolicited:err", 128'(Err), 128'd1);
    applyStimulus(1, 0, '0, 0, "mbreq");
    applyStimulus(0, 1, randBeat(), 0, "mbbeat");
    checkOutput("midburst:outst", 128'(Outstanding), 128'd3);
    ReqRead = 1'b0;
    MDvalid = 1'b0;
    RDen    = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    modelQ.delete();
    modelOut = 0;
    modelErr = 1'b0;
    checkAll("asyncreset");
    checkOutput("asyncreset:rd", RD, 128'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // random traffic, with occasional protocol violations
    doReset();
    for (int c = 0; c < 1500; c++) begin
      req  = modelCan() ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      mdv  = (modelOut > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0);
      rden = (modelQ.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      applyStimulus(req, mdv, randBeat(), rden, "random");
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/rd_buffer.md
Name: rd_buffer

Overview:
- Single-clock read-return buffer: the read-direction counterpart of the DDR write buffer.
- Memory side pushes 128-bit read-data beats returned by the DDR data path; user side pops them through a first-word-fall-through interface.
- A reservation counter guarantees space for every outstanding read before the controller issues it, so returning data is never dropped.
- Sits between the DDR PHY read capture and the user/cache read port.

Parameters:
- DEPTH_LOG2, 6, log2 of buffer depth in 128-bit beats (64 entries).
- BURST_BEATS, 4, beats returned per read command; must be at least 1 and at most 2^DEPTH_LOG2.

Ports:
- Clk  in  1  single clock for both sides.
- Reset  in  1  asynchronous, active-high.
- ReqRead  in  1  controller issues one read command this cycle (reserves BURST_BEATS entries).
- CanIssue  out  1  at least BURST_BEATS unreserved free entries; ReqRead is legal only when this is high.
- MD  in  128  read data beat from RAMs.
- MDvalid  in  1  MD valid this cycle.
- RD  out  128  head-of-buffer data (FWFT).
- RDvalid  out  1  RD valid (buffer not empty).
- RDen  in  1  user pops the head; honoured only when RDvalid=1.
- Outstanding  out  DEPTH_LOG2+1  beats reserved but not yet returned.
- Count  out  DEPTH_LOG2+1  beats stored.
- Err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, released synchronously to Clk): wptr=rptr=0, Count=0, Outstanding=0, RD=0, RDvalid=0, Err=0. CanIssue=1 after reset.
- Storage: 2^DEPTH_LOG2 x 128 RAM. Pointers are DEPTH_LOG2 bits and wrap modulo depth. Count and Outstanding are DEPTH_LOG2+1 bits, so the full depth is representable.
- free = 2^DEPTH_LOG2 - Count - Outstanding, computed from registered state only; no input-to-output combinational path.
- CanIssue = (free >= BURST_BEATS).
- Reservation update per cycle: Outstanding_next = Outstanding + (ReqRead_acc ? BURST_BEATS : 0) - (MDvalid_acc ? 1 : 0).
  - ReqRead_acc = ReqRead & CanIssue.
  - MDvalid_acc = MDvalid & (Outstanding != 0).
  - Simultaneous ReqRead and MDvalid net to +BURST_BEATS-1.
- Write: on MDvalid_acc, MD is written at wptr, wptr++, Count++. A beat written in cycle t is visible on RD/RDvalid in cycle t+1, including when the buffer is empty.
- Read: on RDen & RDvalid, rptr++, Count--, and the next entry is presented the following cycle.
  - Simultaneous push and pop leaves Count unchanged.
  - On push and pop at Count=1, RDvalid stays 1 and RD shows the new beat.
- RD and RDvalid are registered. RD holds its value while RDen=0.
- RDvalid = (Count != 0) as seen through the output register stage.
- Errors set Err (sticky until Reset) and otherwise leave state unchanged:
  - ReqRead while CanIssue=0: command dropped.
  - MDvalid while Outstanding=0: beat dropped, no write.
  - RDen while RDvalid=0: ignored.
- Because of reservations, Count+Outstanding never exceeds depth, so pushes never hit a full RAM.
- Reset mid-burst: all state clears immediately. Beats still in flight after Reset deassertion count as unsolicited and set Err; the controller must quiesce the data path around Reset.
- Order: strictly FIFO; beats are returned in arrival order.

Test Plan:
- Reset then idle -> RDvalid=0, Count=0, Outstanding=0, CanIssue=1, Err=0.
- One ReqRead, then 4 beats 0x...01..0x...04 on consecutive cycles, RDen=0 -> Outstanding goes 4,3,2,1,0; Count=4; RD=0x...01 one cycle after first beat. Then RDen held 4 cycles -> RD 01,02,03,04, then RDvalid=0.
- Issue 16 ReqReads (64 beats reserved) -> CanIssue drops after the 16th; a 17th ReqRead sets Err=1 and Outstanding stays 64. Pop 4 beats after they arrive -> CanIssue returns to 1.
- Wrap-around: stream 200 beats with RDen=1 every cycle and ReqRead whenever CanIssue -> output sequence matches input exactly, no Err, pointers wrap 3 times.
- Simultaneous push and pop at Count=1 -> Count stays 1, RD advances to the new beat with no RDvalid bubble.
- MDvalid with Outstanding=0 -> Err=1, Count unchanged. Then assert Reset mid-burst (Outstanding=3) -> all outputs return to reset values asynchronously.
